// File: rtl/prbs_pkg.sv
// prbs_pkg: mode/state enums, tap table and the step/popcount helpers
// shared by the PRBS generator and checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'b00,
    PRBS15 = 2'b01,
    PRBS23 = 2'b10,
    PRBS31 = 2'b11
  } prbs_mode_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  typedef struct packed {
    logic [30:0] state;
    logic [31:0] bits;
  } prbs_res_t;

  localparam int N7  = 7;
  localparam int N15 = 15;
  localparam int N23 = 23;
  localparam int N31 = 31;
  localparam int T7  = 6;
  localparam int T15 = 14;
  localparam int T23 = 18;
  localparam int T31 = 28;

  // Bit index of the N tap (N-1).
  function automatic logic [4:0] tap_n(prbs_mode_t m);
    logic [4:0] r;
    case (m)
      PRBS7:   r = 5'(N7 - 1);
      PRBS15:  r = 5'(N15 - 1);
      PRBS23:  r = 5'(N23 - 1);
      default: r = 5'(N31 - 1);
    endcase
    return r;
  endfunction

  // Bit index of the T tap (T-1).
  function automatic logic [4:0] tap_t(prbs_mode_t m);
    logic [4:0] r;
    case (m)
      PRBS7:   r = 5'(T7 - 1);
      PRBS15:  r = 5'(T15 - 1);
      PRBS23:  r = 5'(T23 - 1);
      default: r = 5'(T31 - 1);
    endcase
    return r;
  endfunction

  // All-ones in the low N bits, zero above.
  function automatic logic [30:0] seed_state(prbs_mode_t m);
    return 31'h7FFF_FFFF >> (5'd30 - tap_n(m));
  endfunction

  function automatic logic [5:0] popcount(logic [31:0] x);
    logic [5:0]  c;
    logic [31:0] v;
    c = '0;
    v = x;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[0]};
      v = v >> 1;
    end
    return c;
  endfunction

  // Advance nbits steps; bits holds them oldest-first in [nbits-1:0].
  function automatic prbs_res_t prbs_step(
    logic [30:0] state,
    prbs_mode_t  mode,
    int unsigned nbits
  );
    prbs_res_t  r;
    logic [4:0] n;
    logic [4:0] t;
    logic       nb;
    r.state = state;
    r.bits  = '0;
    n = tap_n(mode);
    t = tap_t(mode);
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < nbits) begin
        nb      = r.state[n] ^ r.state[t];
        r.state = {r.state[29:0], nb};
        r.bits  = {r.bits[30:0], nb};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_gen_chk_chk.sv
// prbs_chk: self-synchronising PRBS checker (HUNT/LOCKED), saturating errors.
// Ports: i_clk, i_rst_n, i_mode, i_seed_load, i_data/i_valid, i_err_clr -> o_locked, o_err_cnt.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  prbs_mode_t           i_mode,
  input  logic                 i_seed_load,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_valid,
  input  logic                 i_err_clr,
  output logic                 o_locked,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int SW = ERR_CNT_W + 7;
  localparam logic [ERR_CNT_W-1:0] EMAX = '1;

  chk_state_t           r_state, w_state_nxt;
  logic [30:0]          r_hist, w_hist_nxt;
  logic [30:0]          r_lfsr, w_lfsr_nxt;
  logic [5:0]           r_fill, w_fill_nxt;
  logic [GW-1:0]        r_good, w_good_nxt;
  logic [BW-1:0]        r_bad, w_bad_nxt;
  logic [ERR_CNT_W-1:0] r_err;

  prbs_res_t            w_res;
  logic [DATA_W-1:0]    w_exp;
  logic [5:0]           w_nerr;
  logic [30:0]          w_hist;
  logic [DATA_W-1:0]    w_sh;
  logic                 w_miss;
  logic                 w_clean;
  logic [6:0]           w_fill_sum;
  logic [5:0]           w_fill_inc;
  logic [SW-1:0]        w_sum;
  logic                 w_cnt_add;
  logic                 w_unused;

  assign w_res    = prbs_step(r_lfsr, i_mode, DATA_W);
  assign w_exp    = w_res.bits[DATA_W-1:0];
  assign w_nerr   = popcount(32'(i_data ^ w_exp));
  assign w_unused = ^w_res.bits;

  // Self-sync prediction: each bit from the N/T taps of the
  // history, which already includes earlier bits of this word.
  always_comb begin
    w_hist = r_hist;
    w_sh   = i_data;
    w_miss = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w_miss = w_miss
             | (w_hist[tap_n(i_mode)]
             ^  w_hist[tap_t(i_mode)]
             ^  w_sh[DATA_W-1]);
      w_hist = {w_hist[29:0], w_sh[DATA_W-1]};
      w_sh   = w_sh << 1;
    end
  end

  // A word is only trustworthy once N bits preceded it.
  assign w_clean = !w_miss
                && (r_fill > {1'b0, tap_n(i_mode)});

  assign w_fill_sum = 7'(r_fill) + 7'(DATA_W);
  assign w_fill_inc = (w_fill_sum > 7'd32)
                    ? 6'd32 : w_fill_sum[5:0];

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_lfsr_nxt  = r_lfsr;
    w_fill_nxt  = r_fill;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_cnt_add   = 1'b0;
    if (i_seed_load) begin
      w_state_nxt = HUNT;
      w_fill_nxt  = '0;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else if (i_valid) begin
      w_hist_nxt = w_hist;
      w_fill_nxt = w_fill_inc;
      unique case (r_state)
        HUNT: begin
          if (!w_clean) begin
            w_good_nxt = '0;
          end else if (r_good == GW'(LOCK_CNT - 1)) begin
            w_state_nxt = LOCKED;
            w_good_nxt  = '0;
            w_lfsr_nxt  = w_hist;
          end else begin
            w_good_nxt = r_good + 1'b1;
          end
        end
        LOCKED: begin
          w_lfsr_nxt = w_res.state;
          w_cnt_add  = 1'b1;
          if (w_nerr == '0) begin
            w_bad_nxt = '0;
          end else if (r_bad == BW'(LOSS_CNT - 1)) begin
            w_state_nxt = HUNT;
            w_bad_nxt   = '0;
            w_good_nxt  = '0;
            w_fill_nxt  = '0;
          end else begin
            w_bad_nxt = r_bad + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_sum = SW'(r_err) + SW'(w_nerr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
      r_hist  <= '0;
      r_lfsr  <= '0;
      r_fill  <= '0;
      r_good  <= '0;
      r_bad   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_fill  <= w_fill_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
      if (i_err_clr) begin
        r_err <= '0;
      end else if (w_cnt_add) begin
        r_err <= (w_sum > SW'(EMAX))
               ? EMAX : w_sum[ERR_CNT_W-1:0];
      end
    end
  end

  assign o_locked  = (r_state == LOCKED);
  assign o_err_cnt = r_err;

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: run-time selectable PRBS7/15/23/31 generator + checker.
// Ports: clk, rst_n, mode, seed_load, en, inject_err -> gen_data/gen_valid; chk_data/chk_valid, err_clr -> locked, err_cnt.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 seed_load,
  input  logic                 en,
  input  logic                 inject_err,
  output logic [DATA_W-1:0]    gen_data,
  output logic                 gen_valid,
  input  logic [DATA_W-1:0]    chk_data,
  input  logic                 chk_valid,
  input  logic                 err_clr,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  prbs_mode_t        r_mode;
  logic [30:0]       r_state;
  logic [DATA_W-1:0] r_gen_data;
  logic              r_gen_valid;

  prbs_res_t         w_res;
  logic [DATA_W-1:0] w_word;
  logic              w_unused;

  assign w_res    = prbs_step(r_state, r_mode, DATA_W);
  assign w_unused = ^w_res.bits;

  // Error injection touches the output word only, never the LFSR.
  assign w_word = w_res.bits[DATA_W-1:0]
                ^ DATA_W'(inject_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= PRBS7;
      r_state     <= seed_state(PRBS7);
      r_gen_data  <= '0;
      r_gen_valid <= 1'b0;
    end else if (seed_load) begin
      r_mode      <= prbs_mode_t'(mode);
      r_state     <= seed_state(prbs_mode_t'(mode));
      r_gen_valid <= 1'b0;
    end else if (en) begin
      r_state     <= w_res.state;
      r_gen_data  <= w_word;
      r_gen_valid <= 1'b1;
    end else begin
      r_gen_valid <= 1'b0;
    end
  end

  assign gen_data  = r_gen_data;
  assign gen_valid = r_gen_valid;

  prbs_chk #(
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W),
    .LOCK_CNT  (LOCK_CNT),
    .LOSS_CNT  (LOSS_CNT)
  ) u_chk (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (r_mode),
    .i_seed_load (seed_load),
    .i_data      (chk_data),
    .i_valid     (chk_valid),
    .i_err_clr   (err_clr),
    .o_locked    (locked),
    .o_err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: randomized + directed bench for prbs_gen_chk against
// a sequence-level reference model (bit recurrence on queues).
module tb_prbs_gen_chk;

  localparam int DW   = 8;
  localparam int EW   = 6;
  localparam int LK   = 4;
  localparam int LS   = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          seed_load = 1'b0;
  logic          en = 1'b0;
  logic          inject_err = 1'b0;
  logic [DW-1:0] gen_data;
  logic          gen_valid;
  logic [DW-1:0] chk_data = '0;
  logic          chk_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic          locked;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  prbs_gen_chk #(
    .DATA_W    (DW),
    .ERR_CNT_W (EW),
    .LOCK_CNT  (LK),
    .LOSS_CNT  (LS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .seed_load  (seed_load),
    .en         (en),
    .inject_err (inject_err),
    .gen_data   (gen_data),
    .gen_valid  (gen_valid),
    .chk_data   (chk_data),
    .chk_valid  (chk_valid),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // ---------------- reference model ----------------
  int            g_mode;
  bit            g_seq[$];
  logic [DW-1:0] m_gdata;
  bit            m_gvalid;
  bit            m_lock;
  int            m_good, m_bad, m_fill, m_err;
  bit            rx[$];
  bit            ex[$];

  function automatic int tn(int m);
    return (m == 0) ? 7 : (m == 1) ? 15 : (m == 2) ? 23 : 31;
  endfunction

  function automatic int tt(int m);
    return (m == 0) ? 6 : (m == 1) ? 14 : (m == 2) ? 18 : 28;
  endfunction

  // Sequence preceded by N ones == all-ones LFSR start.
  function automatic void seed_gen();
    g_seq.delete();
    for (int i = 0; i < tn(g_mode); i++) g_seq.push_back(1'b1);
  endfunction

  function automatic void model_reset();
    g_mode = 0;
    seed_gen();
    m_gdata = '0;
    m_gvalid = 1'b0;
    m_lock = 1'b0;
    m_good = 0;
    m_bad = 0;
    m_fill = 0;
    m_err = 0;
    rx.delete();
    ex.delete();
  endfunction

  // Smallest k at which the N-bit window is all ones again.
  function automatic int period(int n, int t);
    bit q[$];
    int ones;
    bit nb, old;
    ones = n;
    for (int i = 0; i < n; i++) q.push_back(1'b1);
    for (int k = 1; k <= 70000; k++) begin
      nb = q[0] ^ q[n-t];
      q.push_back(nb);
      old = q.pop_front();
      ones = ones + int'(nb) - int'(old);
      if (ones == n) return k;
    end
    return 0;
  endfunction

  task automatic model_step();
    int n, t, errs, sz;
    bit clean, b, e;
    logic [DW-1:0] w;
    n = tn(g_mode);
    t = tt(g_mode);
    errs = 0;
    if (seed_load) begin
      m_lock = 1'b0;
      m_good = 0;
      m_bad = 0;
      m_fill = 0;
    end else if (chk_valid) begin
      clean = (m_fill >= n);
      for (int i = DW - 1; i >= 0; i--) begin
        b = chk_data[i];
        if (m_lock) begin
          sz = ex.size();
          e = ex[sz-n] ^ ex[sz-t];
          ex.push_back(e);
          if (e != b) errs++;
        end else if (m_fill >= n) begin
          sz = rx.size();
          if ((rx[sz-n] ^ rx[sz-t]) != b) clean = 1'b0;
        end
        rx.push_back(b);
      end
      m_fill = (m_fill + DW > 32) ? 32 : m_fill + DW;
      if (!m_lock) begin
        if (clean) begin
          m_good++;
          if (m_good == LK) begin
            m_lock = 1'b1;
            m_good = 0;
            ex = rx;
          end
        end else begin
          m_good = 0;
        end
      end else begin
        m_err = (m_err + errs > EMAX) ? EMAX : m_err + errs;
        if (errs > 0) begin
          m_bad++;
          if (m_bad == LS) begin
            m_lock = 1'b0;
            m_bad = 0;
            m_good = 0;
            m_fill = 0;
          end
        end else begin
          m_bad = 0;
        end
      end
      while (rx.size() > 64) void'(rx.pop_front());
      while (ex.size() > 64) void'(ex.pop_front());
    end
    if (err_clr) m_err = 0;
    if (seed_load) begin
      g_mode = int'(mode);
      seed_gen();
      m_gvalid = 1'b0;
    end else if (en) begin
      w = '0;
      for (int i = 0; i < DW; i++) begin
        sz = g_seq.size();
        b = g_seq[sz-n] ^ g_seq[sz-t];
        g_seq.push_back(b);
        w = {w[DW-2:0], b};
      end
      m_gdata = w ^ DW'(inject_err);
      m_gvalid = 1'b1;
      while (g_seq.size() > 64) void'(g_seq.pop_front());
    end else begin
      m_gvalid = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("gen_valid", 32'(gen_valid), 32'(m_gvalid));
      check("gen_data", 32'(gen_data), 32'(m_gdata));
      check("locked", 32'(locked), 32'(m_lock));
      check("err_cnt", 32'(err_cnt), m_err);
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic loopw(int k);
    for (int i = 0; i < k; i++) begin
      chk_valid = m_gvalid;
      chk_data  = m_gdata;
      tick();
    end
  endtask

  int nw, lk;

  initial begin
    model_reset();
    chk_on = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    check("rst_gen_data", 32'(gen_data), 0);
    check("rst_gen_valid", 32'(gen_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;

    // PRBS7 first words
    mode = 2'd0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    en = 1'b1;
    tick();
    check("w1_model", 32'(m_gdata), 32'h02);
    check("w1_dut", 32'(gen_data), 32'h02);
    tick();
    check("w2_model", 32'(m_gdata), 32'h0C);
    check("w2_dut", 32'(gen_data), 32'h0C);
    en = 1'b0;
    tick();
    check("p7_period", period(7, 6), 127);
    check("p15_period", period(15, 14), 32767);

    // PRBS31 loopback lock
    mode = 2'd3;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    en = 1'b1;
    nw = 0;
    lk = 0;
    for (int c = 0; c < 40 && lk == 0; c++) begin
      chk_valid = m_gvalid;
      chk_data  = m_gdata;
      if (m_gvalid) nw++;
      tick();
      if (locked) lk = nw;
    end
    check("lock_latency", lk, 8);
    loopw(2000);
    check("clean_err", 32'(err_cnt), 0);
    check("clean_lock", 32'(locked), 1);

    // single injected error
    inject_err = 1'b1;
    loopw(1);
    inject_err = 1'b0;
    loopw(3);
    check("inject_err_cnt", 32'(err_cnt), 1);
    check("inject_lock", 32'(locked), 1);

    // clear coinciding with the errored word
    inject_err = 1'b1;
    loopw(1);
    inject_err = 1'b0;
    err_clr = 1'b1;
    loopw(1);
    err_clr = 1'b0;
    loopw(3);
    check("clr_wins", 32'(err_cnt), 0);

    // loss of lock on constant input
    nw = 0;
    for (int c = 0; c < 20 && locked; c++) begin
      chk_valid = 1'b1;
      chk_data  = 8'hFF;
      tick();
      nw++;
    end
    check("loss", 32'(locked), 0);
    check("loss_min_words", 32'(nw >= LS), 1);

    // relock after history refills
    nw = 0;
    lk = 0;
    for (int c = 0; c < 40 && lk == 0; c++) begin
      chk_valid = m_gvalid;
      chk_data  = m_gdata;
      if (m_gvalid) nw++;
      tick();
      if (locked) lk = nw;
    end
    check("relock", lk, 8);

    // saturation: errored words interleaved with clean ones
    for (int c = 0; c < 80; c++) begin
      chk_valid = 1'b1;
      chk_data  = m_gdata ^ DW'($urandom_range(1, 255));
      tick();
      loopw(1);
    end
    check("sat_err", 32'(err_cnt), EMAX);
    check("sat_lock", 32'(locked), 1);

    // asynchronous reset mid-cycle
    en = 1'b0;
    chk_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_gen_data", 32'(gen_data), 0);
    check("arst_gen_valid", 32'(gen_valid), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // randomized mixed traffic
    for (int c = 0; c < 3000; c++) begin
      mode       = 2'($urandom_range(0, 3));
      seed_load  = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 3) != 0);
      inject_err = ($urandom_range(0, 31) == 0);
      err_clr    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        chk_valid = 1'($urandom_range(0, 1));
        chk_data  = DW'($urandom);
      end else begin
        chk_valid = m_gvalid;
        chk_data  = m_gdata;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised pseudo-random bit-sequence generator and self-synchronising checker for link and pad bring-up on the Tiny Tapeout tile. It selects PRBS7/15/23/31 at run time and emits DATA_W bits per enabled cycle. A checker locks onto an incoming stream and counts bit errors with saturation. It generalises the single-polynomial PRBS31 pattern source into a multi-mode, multi-bit-per-cycle generator/checker pair.

## Interface
- DATA_W, 8: bits produced/checked per cycle, 1..32
- ERR_CNT_W, 16: error counter width
- LOCK_CNT, 4: consecutive clean words needed to declare lock
- LOSS_CNT, 4: consecutive errored words that drop lock
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  00=PRBS7 (x^7+x^6+1), 01=PRBS15 (x^15+x^14+1), 10=PRBS23 (x^23+x^18+1), 11=PRBS31 (x^31+x^28+1)
- seed_load  in  1  latch mode, reload generator to all-ones, return checker to HUNT
- en  in  1  advance generator by DATA_W bits
- inject_err  in  1  invert gen_data[0] for this word only
- gen_data  out  DATA_W  generated word, MSB = oldest bit
- gen_valid  out  1  gen_data is new this cycle
- chk_data  in  DATA_W  received word, MSB = oldest bit
- chk_valid  in  1  chk_data is valid
- err_clr  in  1  synchronous clear of err_cnt
- locked  out  1  checker in LOCKED
- err_cnt  out  ERR_CNT_W  saturating bit-error count

## Operation
- Generator: Fibonacci LFSR, 31-bit state, low N bits active (N=7/15/23/31). Per bit: new = s[N-1]^s[T-1], where T=6/14/18/28. State shifts left with new in bit 0; output bit = new.
- A word is DATA_W consecutive new bits, first-generated in gen_data[DATA_W-1].
- Reset and seed_load: active state = all-ones, upper unused bits = 0, mode_q = mode. mode is otherwise ignored.
- seed_load and en in the same cycle: seed_load wins and no word is produced.
- inject_err: XOR gen_data[0] in the output register only. LFSR state is untouched.
- Checker FSM states: HUNT, LOCKED. Mode comes from mode_q.
- HUNT: each valid word updates a 31-bit received-history register. Prediction is self-synchronising: bit k = r[k-N]^r[k-T], drawn from history plus earlier bits of the same word.
  - good_cnt counts consecutive words with zero mismatches. It clears on any mismatch.
  - Predictions are meaningless until at least N bits have been received; those words count as mismatched.
  - When good_cnt reaches LOCK_CNT: go to LOCKED and load the checker LFSR from the history.
- LOCKED: expected word comes from the checker's own LFSR, advanced per valid word.
  - err_cnt += popcount(chk_data ^ expected), saturating at all-ones.
  - bad_cnt counts consecutive words with ≥1 error. It clears on a clean word.
  - When bad_cnt reaches LOSS_CNT: go to HUNT and clear good_cnt.
- Errors are never counted in HUNT.
- err_clr together with counted errors in the same cycle: the clear wins and that word's errors are discarded.
- chk_valid low: no state, counter or FSM change.

## Timing
- Reset values: gen_data=0, gen_valid=0, locked=0, err_cnt=0, FSM=HUNT, mode_q=PRBS7. All counters 0.
- gen_data/gen_valid are registered. en in cycle n gives the word in cycle n+1. gen_valid=en delayed one cycle.
- locked and err_cnt are registered, updated the cycle after the qualifying chk_valid.
- locked rises one cycle after the LOCK_CNT-th clean word. Minimum lock latency from first valid word is ceil(N/DATA_W)+LOCK_CNT words.
- Asynchronous reset mid-stream immediately forces all reset values. Nothing is retained.
- Back-to-back en/chk_valid every cycle is supported. There is no backpressure.

## Structure
- Package prbs_pkg holds:
  - mode enum prbs_mode_t
  - tap constants (N, T per mode)
  - function prbs_step(state, mode), returning the next state and DATA_W output bits
  - function popcount
- Sub-module prbs_chk holds the checker FSM, history, checker LFSR and err_cnt.
- The generator is inline in prbs_gen_chk.

## Test plan
- Reset, DATA_W=8, mode=00, seed_load, en for 2 cycles -> gen_data 8'h02 then 8'h0C.
- DATA_W=1, each mode, en continuous -> sequence period exactly 127 / 32767 bits (PRBS23/31: no repeat within 10^6 bits). All-zero state never reached.
- gen_data looped to chk_data, mode=11 -> locked=1 after ceil(31/8)+4=8 words, err_cnt stays 0 for 10^4 words.
- Locked loopback, inject_err once -> err_cnt=1 exactly, locked stays 1. Then err_clr and inject_err in the same cycle -> err_cnt=0.
- Locked, chk_data replaced by constant 8'hFF for 4 words -> locked drops after the 4th word. Restore loopback -> relock after LOCK_CNT clean words once history refills.
- ERR_CNT_W=4, errored random input while locked -> err_cnt saturates at 4'hF, never wraps. rst_n pulsed mid-run -> all outputs return to reset values in the same cycle.
